fp64_addsub_scheduler: RTL and testbench

Shares one 64-bit floating-point add/subtract unit between two requesters. Round-robin arbitration picks a requester and captures its operands. The scheduler then clears, loads and enables the unit, waits for the unit's `ready`, and returns the tagged result through a valid/ready result port. A watchdog guards against a unit that never raises `ready`.

---
 rtl/fp64_sched_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 35 +++
 rtl/fp64_addsub_scheduler.sv | 133 +++++++++++++
 tb/tb_fp64_addsub_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp64_sched_pkg.sv
// Shared types and constants for the fp64 add/sub scheduler.
// Holds the FSM state encoding and the abort result pattern.
package fp64_sched_pkg;

    localparam int TAG_W = 1;

    localparam logic [63:0] FP64_QNAN = 64'h7FF8_0000_0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        RUN,
        RESP
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a one-hot grant.
// The requester that did not win last time takes a tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic last_grant_q;
    logic last_grant_d;

    // Grant decode and round-robin pointer update
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_grant_q ? 2'b01 : 2'b10;
        end
        last_grant_d = last_grant_q;
        if (en_i && (req_i != 2'b00)) begin
            last_grant_d = gnt_o[1];
        end
    end

    // Pointer starts at 1 so requester 0 wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/fp64_addsub_scheduler.sv
// Shares one fp64 add/sub unit between two requesters.
// Sequences clear/load/run on the unit, with a watchdog abort.
module fp64_addsub_scheduler
    import fp64_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [63:0]      req0_a,
    input  logic [63:0]      req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [63:0]      req1_a,
    input  logic [63:0]      req1_b,
    input  logic             req1_sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [63:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_timeout,
    output logic             busy,
    output logic [15:0]      op_count,
    output logic             fu_rst,
    output logic             fu_en,
    output logic             fu_load,
    output logic             fu_plus_or_minus,
    output logic             fu_cin,
    output logic [63:0]      fu_a,
    output logic [63:0]      fu_b,
    input  logic [63:0]      fu_sum,
    input  logic             fu_ready
);

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    sched_state_t state_q, state_d;

    logic [63:0]      a_q, b_q;
    logic             sub_q;
    logic [TAG_W-1:0] tag_q;
    logic [63:0]      data_q;
    logic             to_q;
    logic [15:0]      wd_q;
    logic [15:0]      cnt_q;

    logic [1:0] gnt;
    logic       grant_en;
    logic       take;
    logic       wd_hit;

    assign grant_en = (state_q == IDLE) && !rst;
    assign take     = grant_en && (gnt != 2'b00);
    assign wd_hit   = (wd_q == WD_LAST);

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i ({req1_valid, req0_valid}),
        .en_i  (grant_en),
        .gnt_o (gnt)
    );

    assign req0_ready = take && gnt[0];
    assign req1_ready = take && gnt[1];

    // Next-state sequencing of one operation
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (take) state_d = CLEAR;
            CLEAR: state_d = LOAD;
            LOAD:  state_d = RUN;
            RUN:   if (fu_ready || wd_hit) state_d = RESP;
            RESP:  if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, operand capture, watchdog, result and completion count
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
            to_q    <= 1'b0;
            wd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                a_q   <= gnt[1] ? req1_a : req0_a;
                b_q   <= gnt[1] ? req1_b : req0_b;
                sub_q <= gnt[1] ? req1_sub : req0_sub;
                tag_q <= gnt[1];
            end
            wd_q <= (state_q == RUN) ? wd_q + 16'd1 : 16'd0;
            if (state_q == RUN) begin
                if (fu_ready) begin
                    data_q <= fu_sum;
                    to_q   <= 1'b0;
                end else if (wd_hit) begin
                    data_q <= FP64_QNAN;
                    to_q   <= 1'b1;
                end
            end
            if ((state_q == RESP) && res_ready) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign busy             = (state_q != IDLE);
    assign res_valid        = (state_q == RESP);
    assign res_data         = data_q;
    assign res_tag          = tag_q;
    assign res_timeout      = to_q;
    assign op_count         = cnt_q;
    assign fu_rst           = rst || (state_q == CLEAR);
    assign fu_load          = (state_q == LOAD);
    assign fu_en            = (state_q == LOAD) || (state_q == RUN);
    assign fu_plus_or_minus = sub_q;
    assign fu_cin           = 1'b0;
    assign fu_a             = a_q;
    assign fu_b             = b_q;

endmodule

// File: tb/tb_fp64_addsub_scheduler.sv
// Bench for the fp64 add/sub scheduler: a stand-in adder unit,
// a transaction-level model with per-cycle compare, directed vectors.
module tb_fp64_addsub_scheduler;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_sub, req1_sub;
    logic        res_valid, res_ready;
    logic [63:0] res_data;
    logic [0:0]  res_tag;
    logic        res_timeout, busy;
    logic [15:0] op_count;
    logic        fu_rst, fu_en, fu_load, fu_plus_or_minus, fu_cin;
    logic [63:0] fu_a, fu_b, fu_sum;
    logic        fu_ready;

    fp64_addsub_scheduler #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_tag(res_tag),
        .res_timeout(res_timeout), .busy(busy), .op_count(op_count),
        .fu_rst(fu_rst), .fu_en(fu_en), .fu_load(fu_load),
        .fu_plus_or_minus(fu_plus_or_minus), .fu_cin(fu_cin),
        .fu_a(fu_a), .fu_b(fu_b), .fu_sum(fu_sum), .fu_ready(fu_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] calc(input logic [63:0] a,
                                         input logic [63:0] b,
                                         input logic s);
        real ra, rb;
        ra = $bitstoreal(a);
        rb = $bitstoreal(b);
        return $realtobits(s ? ra - rb : ra + rb);
    endfunction

    // Stand-in unit: ready fu_lat cycles after load, latched until
    // fu_rst; fu_lat = 0 means it never answers.
    int fu_lat = 3;
    int fu_cnt = 0;
    bit fu_act = 1'b0;
    always @(posedge clk) begin
        if (fu_rst) begin
            fu_ready <= 1'b0;
            fu_act   <= 1'b0;
            fu_cnt   <= 0;
        end else if (fu_load && fu_en) begin
            fu_sum <= calc(fu_a, fu_b, fu_plus_or_minus);
            fu_act <= (fu_lat > 0);
            if (fu_lat == 1) fu_ready <= 1'b1;
            fu_cnt <= fu_lat - 1;
        end else if (fu_act && fu_en && !fu_ready) begin
            if (fu_cnt == 1) fu_ready <= 1'b1;
            fu_cnt <= fu_cnt - 1;
        end
    end

    // Transaction model: one outstanding op, spec timing relative to grant
    bit          outs = 1'b0;
    bit          last_m = 1'b1;
    int          g, lat, ph;
    int          cnt_m = 0;
    logic [63:0] ea, eb, ed;
    bit          esub, etag, eto, erv, seen_rv;
    logic [1:0]  v_m, w_m;
    int          obs_lat = 0;
    logic [63:0] hs_data;
    bit          hs_tag, hs_to;
    int          glog[$];
    int          gcyc[$];
    int          hcyc[$];
    logic [63:0] hlog[$];

    always @(negedge clk) begin
        if (rst) begin
            chk("fu_rst_in_reset", fu_rst, 1);
            chk("ready_in_reset", {req1_ready, req0_ready}, 0);
            outs   = 1'b0;
            last_m = 1'b1;
            cnt_m  = 0;
        end else begin
            ph  = outs ? cyc - g : -1;
            erv = outs && (ph >= lat);
            chk("busy", busy, outs);
            chk("res_valid", res_valid, erv);
            chk("fu_en", fu_en, outs && ph >= 2 && ph < lat);
            chk("fu_load", fu_load, outs && ph == 2);
            chk("fu_rst", fu_rst, outs && ph == 1);
            chk("fu_cin", fu_cin, 0);
            chk("op_count", op_count, cnt_m);
            if (outs && ph >= 1 && ph < lat) begin
                chk("fu_a", fu_a, ea);
                chk("fu_b", fu_b, eb);
                chk("fu_pm", fu_plus_or_minus, esub);
            end
            if (erv) begin
                chk("res_data", res_data, ed);
                chk("res_tag", res_tag, etag);
                chk("res_timeout", res_timeout, eto);
            end
            if (outs && res_valid && !seen_rv) begin
                seen_rv = 1'b1;
                obs_lat = cyc - g;
            end
            v_m = {req1_valid, req0_valid};
            w_m = 2'b00;
            if (!outs) begin
                w_m = (v_m == 2'b11) ? (last_m ? 2'b01 : 2'b10) : v_m;
            end
            chk("req_ready", {req1_ready, req0_ready}, w_m);
            if (erv && res_ready) begin
                outs    = 1'b0;
                cnt_m   = (cnt_m + 1) & 16'hFFFF;
                hs_data = res_data;
                hs_tag  = res_tag;
                hs_to   = res_timeout;
                hlog.push_back(res_data);
                hcyc.push_back(cyc);
            end else if (w_m != 2'b00) begin
                outs    = 1'b1;
                g       = cyc;
                seen_rv = 1'b0;
                etag    = w_m[1];
                last_m  = w_m[1];
                ea      = etag ? req1_a : req0_a;
                eb      = etag ? req1_b : req0_b;
                esub    = etag ? req1_sub : req0_sub;
                if (fu_lat == 0 || fu_lat > T) begin
                    lat = 3 + T;
                    ed  = 64'h7FF8_0000_0000_0000;
                    eto = 1'b1;
                end else begin
                    lat = 3 + fu_lat;
                    ed  = calc(ea, eb, esub);
                    eto = 1'b0;
                end
                glog.push_back(int'(etag));
                gcyc.push_back(cyc);
            end
        end
    end

    task automatic issue(input bit p, input logic [63:0] a,
                         input logic [63:0] b, input bit s);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        if (p) begin
            req1_a = a; req1_b = b; req1_sub = s; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_sub = s; req0_valid = 1'b1;
        end
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = p ? req1_ready : req0_ready;
        end
        chk("issue_granted", got, 1);
        @(posedge clk); #1;
        if (p) req1_valid = 1'b0;
        else req0_valid = 1'b0;
    endtask

    task automatic wait_ops(input int n);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            k++;
        end while (cnt_m < n && k < 300);
        chk("ops_done", cnt_m >= n, 1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int gb, hb;
        bit seen;
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_sub = 0;
        req1_a = 0; req1_b = 0; req1_sub = 0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_fu_en", fu_en, 0);
        chk("rst_fu_rst", fu_rst, 0);

        // single add 1.0 + 2.0
        fu_lat = 3;
        issue(0, 64'h3FF0000000000000, 64'h4000000000000000, 0);
        wait_ops(1);
        chk("add_data", hs_data, 64'h4008000000000000);
        chk("add_tag", hs_tag, 0);
        chk("add_to", hs_to, 0);
        chk("add_lat", obs_lat, 6);
        @(negedge clk);
        chk("add_count", op_count, 1);

        // tie from fresh reset: 3.0-1.0 vs 1.5+0.25
        pulse_reset();
        gb = glog.size(); hb = hlog.size();
        fu_lat = 1;
        req0_a = 64'h4008000000000000; req0_b = 64'h3FF0000000000000;
        req0_sub = 1;
        req1_a = 64'h3FF8000000000000; req1_b = 64'h3FD0000000000000;
        req1_sub = 0;
        req0_valid = 1; req1_valid = 1;
        wait_ops(4);
        #1 req0_valid = 0; req1_valid = 0;
        chk("tie_g0", glog[gb], 0);
        chk("tie_g1", glog[gb + 1], 1);
        chk("tie_g2", glog[gb + 2], 0);
        chk("tie_g3", glog[gb + 3], 1);
        chk("tie_turn", gcyc[gb + 1] - gcyc[gb], 5);
        chk("sub_data", hlog[hb], 64'h4000000000000000);
        chk("add2_data", hlog[hb + 1], 64'h3FFC000000000000);

        // timeout
        fu_lat = 0;
        issue(1, 64'h3FF0000000000000, 64'h3FF0000000000000, 0);
        wait_ops(5);
        chk("to_data", hs_data, 64'h7FF8000000000000);
        chk("to_flag", hs_to, 1);
        chk("to_tag", hs_tag, 1);
        chk("to_lat", obs_lat, 11);

        // backpressure with req1 pending: 5.0+0.5, then 2.0-0.5
        fu_lat = 2;
        gb = gcyc.size(); hb = hcyc.size();
        @(posedge clk); #1 res_ready = 1'b0;
        issue(0, 64'h4014000000000000, 64'h3FE0000000000000, 0);
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            seen = res_valid;
        end
        chk("bp_res_valid", seen, 1);
        @(posedge clk); #1;
        req1_a = 64'h4000000000000000; req1_b = 64'h3FE0000000000000;
        req1_sub = 1; req1_valid = 1;
        repeat (10) @(posedge clk);
        #1 res_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = req1_ready;
        end
        chk("bp_req1_granted", seen, 1);
        @(posedge clk); #1 req1_valid = 0;
        wait_ops(7);
        chk("bp_data", hlog[hb], 64'h4016000000000000);
        chk("bp_next", gcyc[gb + 1] - hcyc[hb], 1);
        chk("bp_tag", glog[gb + 1], 1);
        chk("bp2_data", hlog[hb + 1], 64'h3FF8000000000000);

        // reset during RUN, then tie goes to req0
        fu_lat = 6;
        issue(0, 64'h3FF0000000000000, 64'h3FE0000000000000, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mr_busy", busy, 0);
        chk("mr_res_valid", res_valid, 0);
        chk("mr_fu_en", fu_en, 0);
        chk("mr_op_count", op_count, 0);
        gb = glog.size();
        fu_lat = 1;
        @(posedge clk); #1;
        req0_a = 64'h3FF0000000000000; req0_b = 64'h3FF0000000000000;
        req1_a = 64'h4000000000000000; req1_b = 64'h4000000000000000;
        req0_sub = 0; req1_sub = 0;
        req0_valid = 1; req1_valid = 1;
        wait_ops(2);
        #1 req0_valid = 0; req1_valid = 0;
        chk("mr_first", glog[gb], 0);
        chk("mr_second", glog[gb + 1], 1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
